// File: rtl/alu_arbiter.sv
// Two-requester arbiter around one shared ALU with a single operation in flight.
// Optional op_err output for opcodes 110/111 is enabled by defining ALU_ARBITER_ERR_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; grants one requester combinationally
// EXEC   | down-counting LAT cycles on the latched operands
// RESP   | holding the result until the granted requester consumes it
module alu_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data
`ifdef ALU_ARBITER_ERR_EN
    ,
    output logic        op_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic        r_id;
    logic        r_last;
    logic [31:0] r_rsp_data;
    logic        r_rsp_valid;

    logic        w_idle;
    logic        w_gnt_id;
    logic        w_accept;
    logic        w_rsp_done;
    logic        w_exec_done;
    logic [31:0] w_alu;

    assign w_idle   = (r_state == S_IDLE);
    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    assign w_gnt_id = req1_valid & (~req0_valid | ~r_last);
    assign w_accept = w_idle & (req0_valid | req1_valid);

    assign req0_ready = reset_n & w_accept & ~w_gnt_id;
    assign req1_ready = reset_n & w_accept &  w_gnt_id;

    assign w_exec_done = (r_state == S_EXEC) & (r_cnt == 4'd0);
    assign w_rsp_done  = (r_state == S_RESP) & (r_id ? rsp1_ready : rsp0_ready);

    assign rsp0_valid = r_rsp_valid & ~r_id;
    assign rsp1_valid = r_rsp_valid &  r_id;
    assign rsp_data   = r_rsp_data;

    always_comb begin
        w_alu = 32'd0;
        case (r_op)
            3'b000:  w_alu = r_a + r_b;
            3'b001:  w_alu = r_a - r_b;
            3'b010:  w_alu = r_a & r_b;
            3'b011:  w_alu = r_a | r_b;
            3'b100:  w_alu = r_a >> r_b[4:0];
            3'b101:  w_alu = $unsigned($signed(r_a) >>> r_b[4:0]);
            default: w_alu = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_op        <= 3'd0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt_id ? req1_a  : req0_a;
                        r_b     <= w_gnt_id ? req1_b  : req0_b;
                        r_op    <= w_gnt_id ? req1_op : req0_op;
                        r_id    <= w_gnt_id;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        r_rsp_data  <= w_alu;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // Always fall back to IDLE so a new grant never shares the consume edge.
                    if (w_rsp_done) begin
                        r_rsp_valid <= 1'b0;
                        r_last      <= r_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ARBITER_ERR_EN
    logic r_op_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_err <= 1'b0;
        end else if (w_exec_done) begin
            r_op_err <= (r_op[2:1] == 2'b11);
        end else if (w_rsp_done) begin
            r_op_err <= 1'b0;
        end
    end

    assign op_err = r_op_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized operations against a reference model.
module tb_alu_arbiter;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
`ifdef ALU_ARBITER_ERR_EN
    logic        op_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.LAT(LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data)
`ifdef ALU_ARBITER_ERR_EN
        ,
        .op_err     (op_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint unsigned m  = 64'h1_0000_0000;
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        int              sh = int'(ub % 32);
        longint          sa;
        longint          r;
        case (op)
            3'd0: r = longint'((ua + ub) % m);
            3'd1: r = longint'((ua + m - ub) % m);
            3'd2: r = longint'(ua & ub);
            3'd3: r = longint'(ua | ub);
            3'd4: r = longint'(ua / (64'd1 << sh));
            3'd5: begin
                sa = (ua >= 64'h8000_0000) ? longint'(ua) - longint'(m) : longint'(ua);
                r  = sa >>> sh;
            end
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic rdy(input int id);
        return (id == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rv(input int id);
        return (id == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (id == 1) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // One full transaction for requester id; response held back for 'hold' extra cycles.
    task automatic serve(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] exp, input int hold, input string tag);
        int cyc;
        @(negedge clk);
        drive(id, 1'b1, a, b, op);
        drive(1 - id, 1'b0, 32'd0, 32'd0, 3'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        cyc = 0;
        while (rdy(id) !== 1'b1 && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        check({tag, " grant"}, rdy(id), 1'b1);
        check({tag, " other_ready"}, rdy(1 - id), 1'b0);
        @(negedge clk);
        drive(id, 1'b0, ~a, ~b, ~op);
        drive(1 - id, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
        #1;
        cyc = 1;
        while (rv(id) !== 1'b1 && cyc < 40) begin
            check({tag, " exec_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk); #1; cyc++;
        end
        check({tag, " latency"}, cyc, LAT + 1);
        check({tag, " data"}, rsp_data, exp);
        check({tag, " other_rsp"}, rv(1 - id), 1'b0);
`ifdef ALU_ARBITER_ERR_EN
        check({tag, " op_err"}, op_err, (op[2:1] == 2'b11));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check({tag, " hold_valid"}, rv(id), 1'b1);
            check({tag, " hold_data"}, rsp_data, exp);
            check({tag, " hold_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk); #1;
        check({tag, " consumed"}, {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
`ifdef ALU_ARBITER_ERR_EN
        check({tag, " op_err_clr"}, op_err, 1'b0);
`endif
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        int order[$];
        int grants[$];
        int cyc;
        int n_rsp0, n_rsp1;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        int          rid;

        vecs[0]  = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 3'd0, 32'h0000_0001, 0};
        vecs[1]  = '{1, 32'h8000_0000, 32'h0000_0024, 3'd5, 32'hF800_0000, 0};
        vecs[2]  = '{1, 32'h8000_0000, 32'h0000_0024, 3'd4, 32'h0800_0000, 0};
        vecs[3]  = '{0, 32'h0000_0005, 32'h0000_0007, 3'd1, 32'hFFFF_FFFE, 5};
        vecs[4]  = '{1, 32'h0000_00F0, 32'h0000_000F, 3'd3, 32'h0000_00FF, 0};
        vecs[5]  = '{0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 32'hF000_F000, 0};
        vecs[6]  = '{1, 32'h0000_007B, 32'h0000_0001, 3'd7, 32'h0000_0000, 2};
        vecs[7]  = '{0, 32'hDEAD_BEEF, 32'h1234_5678, 3'd6, 32'h0000_0000, 0};
        vecs[8]  = '{1, 32'h7FFF_FFFF, 32'h0000_001F, 3'd5, 32'h0000_0000, 0};
        vecs[9]  = '{0, 32'h8000_0000, 32'h0000_003F, 3'd5, 32'hFFFF_FFFF, 0};
        vecs[10] = '{1, 32'h8000_0000, 32'h0000_0020, 3'd4, 32'h8000_0000, 0};
        vecs[11] = '{0, 32'h0000_0000, 32'h0000_0001, 3'd1, 32'hFFFF_FFFF, 0};
        vecs[12] = '{1, 32'h8000_0000, 32'h8000_0000, 3'd0, 32'h0000_0000, 1};

        reset_n    = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive(0, 1'b1, 32'd1, 32'd2, 3'd0);
        drive(1, 1'b1, 32'd3, 32'd4, 3'd0);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        check("reset rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);

        // Round-robin from reset: requester 0 takes the first tie.
        @(negedge clk);
        drive(0, 1'b1, 32'd5, 32'd7, 3'd1);
        drive(1, 1'b1, 32'hF0, 32'h0F, 3'd3);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        n_rsp0 = 0;
        n_rsp1 = 0;
        cyc = 0;
        while (order.size() < 3 && cyc < 40) begin
            #1;
            if (req0_ready && req1_ready) check("rr both_ready", 32'd1, 32'd0);
            if (req0_ready) order.push_back(0);
            if (req1_ready) order.push_back(1);
            if (rsp0_valid) begin check("rr rsp0 data", rsp_data, 32'hFFFF_FFFE); n_rsp0++; end
            if (rsp1_valid) begin check("rr rsp1 data", rsp_data, 32'h0000_00FF); n_rsp1++; end
            @(negedge clk);
            cyc++;
        end
        drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
        check("rr grant count", order.size(), 3);
        if (order.size() == 3) begin
            check("rr first", order[0], 0);
            check("rr second", order[1], 1);
            check("rr third", order[2], 0);
        end
        check("rr rsp0 seen", n_rsp0, 1);
        check("rr rsp1 seen", n_rsp1, 1);
        repeat (5) @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Back-to-back issue with the response consumed immediately.
        @(negedge clk);
        drive(0, 1'b1, 32'd1, 32'd1, 3'd0);
        rsp0_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (req0_ready) grants.push_back(c);
            if (rsp0_valid) check("b2b data", rsp_data, 32'd2);
            @(negedge clk);
        end
        drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
        check("b2b grant count", (grants.size() >= 4), 1'b1);
        for (int g = 1; g < grants.size(); g++)
            check($sformatf("b2b gap%0d", g), grants[g] - grants[g-1], LAT + 2);
        repeat (4) @(negedge clk);
        rsp0_ready = 1'b0;

        for (int i = 0; i < 13; i++)
            serve(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].hold,
                  $sformatf("vec%0d", i));

        // Reset pulse while the operation is in EXEC.
        serve(0, 32'h1234_0000, 32'h0000_5678, 3'd3, 32'h1234_5678, 0, "pre_rst");
        @(negedge clk);
        drive(1, 1'b1, 32'h10, 32'h20, 3'd0);
        #1;
        check("rst_exec grant", req1_ready, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_exec data", rsp_data, 32'd0);
        check("rst_exec rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check("rst_exec no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        end
        serve(1, 32'h0000_0030, 32'h0000_0003, 3'd0, 32'h0000_0033, 0, "post_rst");

        for (int k = 0; k < 40; k++) begin
            rid = int'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (k % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            rop = 3'($urandom_range(0, 7));
            serve(rid, ra, rb, rop, model(ra, rb, rop), int'($urandom_range(0, 2)),
                  $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning EXEC-state cycles per operation (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operands of requester N accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1  result for requester N available.
REQ-009 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
REQ-010 SHALL have port rsp_data  output  32  result shared by both response ports, valid only with rspN_valid.

Function
REQ-011 SHALL own exactly one ALU datapath shared by both requesters; SHALL hold at most one operation in flight.
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-013 IDLE: if any reqN_valid, SHALL grant one requester, drive its reqN_ready high combinationally in the same cycle, latch a, b, op and the grant id, then enter EXEC.
REQ-014 Grant SHALL be round-robin: if both valid, the requester not granted last wins; if only one is valid, it wins regardless of history.
REQ-015 reqN_ready SHALL be low outside IDLE and low for the non-granted requester.
REQ-016 EXEC: SHALL count LAT cycles with a 4-bit counter, then register the ALU result into rsp_data and enter RESP.
REQ-017 RESP: SHALL assert rspN_valid for the granted requester only; SHALL hold rsp_data and rspN_valid stable until rspN_ready is high; on that edge SHALL return to IDLE and record the grant as last-granted.
REQ-018 Add and sub SHALL wrap modulo 2^32 with no carry or overflow output.
REQ-019 srl and sra SHALL use only b[4:0] as the shift amount; sra SHALL replicate a[31].
REQ-020 Opcodes 110 and 111 SHALL produce result 0.
REQ-021 Minimum issue-to-issue time SHALL be LAT+2 cycles, with rspN_ready held high.
REQ-022 A new grant SHALL NOT be issued in the same cycle that a response is consumed; IDLE is always at least one cycle.
REQ-023 Operand changes on reqN_* after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-024 reset_n low SHALL immediately set: state IDLE, counter 0, rsp_data 0, rsp0_valid and rsp1_valid 0, last-granted 1 (requester 0 wins the first tie).
REQ-025 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response emitted.
REQ-026 reqN_ready SHALL be 0 while reset_n is low.

Configuration
REQ-027 Macro ALU_ARBITER_ERR_EN defined: SHALL add output port op_err (1 bit); op_err SHALL be set together with rspN_valid when the latched op is 110 or 111, and SHALL clear on response consumption or reset.
REQ-028 Macro ALU_ARBITER_ERR_EN undefined: op_err port SHALL be absent; behaviour is otherwise identical.

Verification
REQ-029 LAT=1; req0 add a=0xFFFFFFFF, b=2 -> req0_ready in cycle 0, rsp0_valid in cycle 2, rsp_data=0x00000001.
REQ-030 Both valid from reset, req0 sub 5-7, req1 or 0xF0|0x0F -> req0 served first with 0xFFFFFFFE, then req1 with 0x000000FF; both held valid again -> req0 next.
REQ-031 req1 sra a=0x80000000, b=0x24 -> shift by 4, result 0xF8000000; srl same operands -> 0x08000000.
REQ-032 rsp0_ready held low for 5 cycles -> rsp0_valid and rsp_data stable, req0_ready and req1_ready low throughout.
REQ-033 reset_n pulsed low during EXEC -> outputs 0 immediately, no rsp_valid afterwards, next request served normally.
REQ-034 op=111 with ALU_ARBITER_ERR_EN defined -> rsp_data=0, op_err=1 with rsp_valid; without the macro -> rsp_data=0 only.
